// File: rtl/i2s_tdm_master_transmitter.sv
// rtl/i2s_tdm_master_transmitter.sv - I2S / left-justified TDM master transmitter with sample FIFO
// Derives SCK/WS from i_CLK and shifts FIFO samples out MSB first, one FIFO pop per slot.
module i2s_tdm_master_transmitter #(
   parameter int DataWidth = 16,
   parameter int SlotWidth = 32,
   parameter int Channels  = 2,
   parameter int ClkDiv    = 4,
   parameter int FifoDepth = 8
) (
   input  logic                           i_CLK,
   input  logic                           i_NRESET,
   input  logic                           i_ENABLE,
   input  logic                           i_Mode,
   input  logic [DataWidth-1:0]           i_Data,
   input  logic                           i_Valid,
   output logic                           o_Ready,
   output logic [$clog2(FifoDepth+1)-1:0] o_Level,
   output logic                           o_SCK,
   output logic                           o_WS,
   output logic                           o_SD,
   output logic                           o_Underrun
);
   localparam int FrameBits = Channels * SlotWidth;
   localparam int BW   = $clog2(FrameBits);
   localparam int KW   = (SlotWidth > 1) ? $clog2(SlotWidth) : 1;
   localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
   localparam int AW   = $clog2(FifoDepth);
   localparam int LW   = $clog2(FifoDepth + 1);
   localparam logic [BW-1:0]   LastBit = BW'(FrameBits - 1);
   localparam logic [BW-1:0]   HalfBit = BW'((Channels / 2) * SlotWidth);
   localparam logic [KW-1:0]   LastK   = KW'(SlotWidth - 1);
   localparam logic [DivW-1:0] LastDiv = DivW'(ClkDiv - 1);
   localparam logic [LW-1:0]   FullLvl = LW'(FifoDepth);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t               r_state;
   logic [DataWidth-1:0] r_mem [FifoDepth];
   logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]        r_level;
   logic [DivW-1:0]      r_div;
   logic [BW-1:0]        r_bit;
   logic [KW-1:0]        r_k;
   logic [DataWidth-1:0] r_shift;
   logic                 r_mode, r_sck, r_ws, r_sd, r_underrun;

   logic                 w_push, w_pop, w_pop_req, w_start, w_fall, w_stop, w_emit, w_mode, w_frame_end;
   logic [BW-1:0]        w_bit;
   logic [KW-1:0]        w_k;
   logic [DataWidth-1:0] w_head;

   assign o_Ready     = i_NRESET & (r_level != FullLvl);
   assign o_Level     = r_level;
   assign o_SCK       = r_sck;
   assign o_WS        = r_ws;
   assign o_SD        = r_sd;
   assign o_Underrun  = r_underrun;

   assign w_push      = i_Valid & o_Ready;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_start     = (r_state == S_IDLE) & i_ENABLE;
   assign w_fall      = (r_state != S_IDLE) & r_sck & (r_div == LastDiv);
   assign w_frame_end = (r_bit == LastBit);
   assign w_stop      = (r_state == S_RUN) & w_fall & w_frame_end & ~i_ENABLE;
   assign w_mode      = (r_state == S_IDLE) ? i_Mode : r_mode;
   assign w_bit       = (w_start | w_frame_end) ? '0 : r_bit + 1'b1;
   assign w_k         = (w_start | (r_k == LastK)) ? '0 : r_k + 1'b1;
   // Every fall event that still drives frame data; stopping in LJ mode and leaving DRAIN do not.
   assign w_emit      = w_start | ((r_state == S_RUN) & w_fall & ~(w_stop & r_mode));
   // The slot's MSB leaves at k=0 in LJ and one SCK later (k=1) in I2S, so that is where it pops.
   assign w_pop_req   = w_emit & (w_mode ? (w_k == '0) : (w_k == KW'(1)));
   assign w_pop       = w_pop_req & (r_level != '0);

   always_ff @(posedge i_CLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_Data;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (!i_NRESET) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_div      <= '0;
         r_bit      <= '0;
         r_k        <= '0;
         r_shift    <= '0;
         r_mode     <= 1'b0;
         r_sck      <= 1'b0;
         r_ws       <= 1'b0;
         r_sd       <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push & ~w_pop)      r_level <= r_level + 1'b1;
         else if (~w_push & w_pop) r_level <= r_level - 1'b1;

         case (r_state)
            S_IDLE: begin
               r_div   <= '0;
               r_bit   <= '0;
               r_k     <= '0;
               r_sck   <= 1'b0;
               r_ws    <= 1'b0;
               r_sd    <= 1'b0;
               r_shift <= '0;
               if (i_ENABLE) begin
                  r_mode     <= i_Mode;
                  r_underrun <= 1'b0;
                  r_state    <= S_RUN;
               end
            end
            default: begin
               r_div <= (r_div == LastDiv) ? '0 : r_div + 1'b1;
               if (r_div == LastDiv) r_sck <= ~r_sck;
               if (w_fall) begin
                  r_bit <= w_bit;
                  r_k   <= w_k;
                  if ((r_state == S_DRAIN) || (w_stop && r_mode)) begin
                     r_state <= S_IDLE;
                     r_ws    <= 1'b0;
                     r_sd    <= 1'b0;
                  end else if (w_stop) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
         endcase

         if (w_emit) begin
            r_ws <= (w_bit >= HalfBit);
            if (w_pop_req) begin
               r_sd    <= w_pop ? w_head[DataWidth-1] : 1'b0;
               r_shift <= w_pop ? (w_head << 1) : '0;
               if (!w_pop) r_underrun <= 1'b1;
            end else begin
               r_sd    <= r_shift[DataWidth-1];
               r_shift <= r_shift << 1;
            end
         end
      end
   end
endmodule
